// File: rtl/mcpu_pkg.sv
// Shared definitions for the MicroCPU ALU sequencer: opcodes, FSM encoding, instruction layout.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package mcpu_pkg;

    // Default geometry of the sequencer and its register file
    localparam int DEF_CMD_SIZE  = 2;
    localparam int DEF_WORD_SIZE = 4;
    localparam int DEF_REG_ADDR  = 2;

    // ALU opcodes as understood by the external combinational ALU
    localparam int OP_AND = 0;
    localparam int OP_OR  = 1;
    localparam int OP_XOR = 2;
    localparam int OP_ADD = 3;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_t;

    // Instruction layout, LSB first: src2, src1, dst, opcode, ldi (MSB)
    function automatic int src2_lsb(input int reg_addr);
        return 0 * reg_addr;
    endfunction

    function automatic int src1_lsb(input int reg_addr);
        return reg_addr;
    endfunction

    function automatic int dst_lsb(input int reg_addr);
        return 2 * reg_addr;
    endfunction

    function automatic int op_lsb(input int reg_addr);
        return 3 * reg_addr;
    endfunction

    function automatic int ldi_bit(input int cmd_size, input int reg_addr);
        return cmd_size + 3 * reg_addr;
    endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// Register file: two combinational operand read ports, one debug read port, one write port.
// Latency: reads are combinational; a write becomes visible the cycle after its write edge.
// Backpressure: none, a write is accepted on every cycle wr_en is high.
module mcpu_regfile
    import mcpu_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int REG_ADDR  = DEF_REG_ADDR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_ADDR-1:0]  rd1_addr,
    output logic [WORD_SIZE-1:0] rd1_data,
    input  logic [REG_ADDR-1:0]  rd2_addr,
    output logic [WORD_SIZE-1:0] rd2_data,
    input  logic [REG_ADDR-1:0]  dbg_addr,
    output logic [WORD_SIZE-1:0] dbg_data,
    input  logic                 wr_en,
    input  logic [REG_ADDR-1:0]  wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data
);

    localparam int NUM_REGS = 1 << REG_ADDR;

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] regs_d [NUM_REGS];

    // Next register contents: only the addressed entry changes on a write
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Storage with synchronous clear of every entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // No write-to-read bypass: readers see the stored value only
    assign rd1_data = regs_q[rd1_addr];
    assign rd2_data = regs_q[rd2_addr];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/mcpu_alu_sequencer.sv
// Sequencer feeding an external ALU: accept instruction, issue operands, capture result, write back.
// Latency: ALU op accept at edge N -> done in cycle N+2; LDI -> done in cycle N+1.
// Backpressure: instr_ready is low in ISSUE/WB; the source must hold its instruction until accepted.
module mcpu_alu_sequencer
    import mcpu_pkg::*;
#(
    parameter int CMD_SIZE  = DEF_CMD_SIZE,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    // 2*REG_ADDR must be >= WORD_SIZE so the immediate fills a whole word
    parameter int REG_ADDR  = DEF_REG_ADDR
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         instr_valid,
    input  logic [CMD_SIZE+3*REG_ADDR:0] instr,
    output logic                         instr_ready,
    output logic                         done,
    output logic                         overflow_flag,
    output logic [CMD_SIZE-1:0]          alu_opcode,
    output logic [WORD_SIZE-1:0]         alu_r1,
    output logic [WORD_SIZE-1:0]         alu_r2,
    input  logic [WORD_SIZE-1:0]         alu_out,
    input  logic                         alu_overflow,
    input  logic [REG_ADDR-1:0]          dbg_addr,
    output logic [WORD_SIZE-1:0]         dbg_data
);

    localparam int SRC2_LSB = src2_lsb(REG_ADDR);
    localparam int SRC1_LSB = src1_lsb(REG_ADDR);
    localparam int DST_LSB  = dst_lsb(REG_ADDR);
    localparam int OP_LSB   = op_lsb(REG_ADDR);
    localparam int LDI_BIT  = ldi_bit(CMD_SIZE, REG_ADDR);

    localparam logic [CMD_SIZE-1:0] OPC_ADD = CMD_SIZE'(OP_ADD);

    // Incoming instruction fields
    logic                     ldi_in;
    logic [CMD_SIZE-1:0]      op_in;
    logic [REG_ADDR-1:0]      dst_in;
    logic [REG_ADDR-1:0]      src1_in;
    logic [REG_ADDR-1:0]      src2_in;
    logic [2*REG_ADDR-1:0]    imm_full;
    logic [WORD_SIZE-1:0]     imm_in;

    assign ldi_in   = instr[LDI_BIT];
    assign op_in    = instr[OP_LSB +: CMD_SIZE];
    assign dst_in   = instr[DST_LSB +: REG_ADDR];
    assign src1_in  = instr[SRC1_LSB +: REG_ADDR];
    assign src2_in  = instr[SRC2_LSB +: REG_ADDR];
    assign imm_full = {src1_in, src2_in};
    assign imm_in   = imm_full[WORD_SIZE-1:0];

    // FSM and datapath state
    state_t                 state_q, state_d;
    logic                   ldi_q, ldi_d;
    logic [CMD_SIZE-1:0]    op_q, op_d;
    logic [REG_ADDR-1:0]    dst_q, dst_d;
    logic [WORD_SIZE-1:0]   result_q, result_d;
    logic                   ovf_tmp_q, ovf_tmp_d;
    logic                   overflow_flag_q, overflow_flag_d;
    logic [CMD_SIZE-1:0]    alu_opcode_q, alu_opcode_d;
    logic [WORD_SIZE-1:0]   alu_r1_q, alu_r1_d;
    logic [WORD_SIZE-1:0]   alu_r2_q, alu_r2_d;

    logic                   accept;
    logic                   rf_we;
    logic [WORD_SIZE-1:0]   rd1_data;
    logic [WORD_SIZE-1:0]   rd2_data;

    // Operands are read straight from the incoming instruction so they are sampled at accept
    mcpu_regfile #(
        .WORD_SIZE (WORD_SIZE),
        .REG_ADDR  (REG_ADDR)
    ) u_regfile (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .rd1_addr (src1_in),
        .rd1_data (rd1_data),
        .rd2_addr (src2_in),
        .rd2_data (rd2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (rf_we),
        .wr_addr  (dst_q),
        .wr_data  (result_q)
    );

    // State register; reset also aborts any operation in flight
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: LDI skips the ALU issue cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ldi_in ? ST_WB : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs: handshake, completion pulse and writeback enable
    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        rf_we       = 1'b0;
        case (state_q)
            ST_IDLE: instr_ready = 1'b1;
            ST_WB: begin
                done  = 1'b1;
                rf_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = instr_valid && instr_ready;

    // Datapath next values: latch on accept, capture the ALU in ISSUE, settle the flag in WB
    always_comb begin
        ldi_d           = ldi_q;
        op_d            = op_q;
        dst_d           = dst_q;
        result_d        = result_q;
        ovf_tmp_d       = ovf_tmp_q;
        overflow_flag_d = overflow_flag_q;
        alu_opcode_d    = alu_opcode_q;
        alu_r1_d        = alu_r1_q;
        alu_r2_d        = alu_r2_q;

        if (accept) begin
            ldi_d = ldi_in;
            op_d  = op_in;
            dst_d = dst_in;
            if (ldi_in) begin
                // The immediate travels through the result register so WB has one write source
                result_d = imm_in;
            end else begin
                alu_opcode_d = op_in;
                alu_r1_d     = rd1_data;
                alu_r2_d     = rd2_data;
            end
        end

        if (state_q == ST_ISSUE) begin
            result_d  = alu_out;
            ovf_tmp_d = alu_overflow;
        end

        // Only ADD produces a carry; logic ops clear the flag, LDI leaves it alone
        if ((state_q == ST_WB) && !ldi_q) begin
            overflow_flag_d = (op_q == OPC_ADD) ? ovf_tmp_q : 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ldi_q           <= 1'b0;
            op_q            <= '0;
            dst_q           <= '0;
            result_q        <= '0;
            ovf_tmp_q       <= 1'b0;
            overflow_flag_q <= 1'b0;
            alu_opcode_q    <= '0;
            alu_r1_q        <= '0;
            alu_r2_q        <= '0;
        end else begin
            ldi_q           <= ldi_d;
            op_q            <= op_d;
            dst_q           <= dst_d;
            result_q        <= result_d;
            ovf_tmp_q       <= ovf_tmp_d;
            overflow_flag_q <= overflow_flag_d;
            alu_opcode_q    <= alu_opcode_d;
            alu_r1_q        <= alu_r1_d;
            alu_r2_q        <= alu_r2_d;
        end
    end

    assign overflow_flag = overflow_flag_q;
    assign alu_opcode    = alu_opcode_q;
    assign alu_r1        = alu_r1_q;
    assign alu_r2        = alu_r2_q;

endmodule

// File: tb/tb_mcpu_alu_sequencer.sv
// Directed bench for mcpu_alu_sequencer with an external ALU and a scoreboard of expected writebacks.
// Latency: n/a.
// Backpressure: the bench holds instructions until instr_ready, as a real source must.
module tb_mcpu_alu_sequencer;

    localparam int CS = 2;
    localparam int WS = 4;
    localparam int RA = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          instr_valid;
    logic [8:0]    instr;
    logic          instr_ready;
    logic          done;
    logic          overflow_flag;
    logic [CS-1:0] alu_opcode;
    logic [WS-1:0] alu_r1;
    logic [WS-1:0] alu_r2;
    logic [WS-1:0] alu_out;
    logic          alu_overflow;
    logic [RA-1:0] dbg_addr;
    logic [WS-1:0] dbg_data;

    always #5 clk = ~clk;

    mcpu_alu_sequencer #(
        .CMD_SIZE  (CS),
        .WORD_SIZE (WS),
        .REG_ADDR  (RA)
    ) dut (
        .CLK           (clk),
        .RESET_N       (reset_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .done          (done),
        .overflow_flag (overflow_flag),
        .alu_opcode    (alu_opcode),
        .alu_r1        (alu_r1),
        .alu_r2        (alu_r2),
        .alu_out       (alu_out),
        .alu_overflow  (alu_overflow),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    // The external combinational ALU the sequencer drives
    logic [WS:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (alu_opcode)
            2'd0:    alu_res = {1'b0, alu_r1 & alu_r2};
            2'd1:    alu_res = {1'b0, alu_r1 | alu_r2};
            2'd2:    alu_res = {1'b0, alu_r1 ^ alu_r2};
            default: alu_res = {1'b0, alu_r1} + {1'b0, alu_r2};
        endcase
    end
    assign alu_out      = alu_res[WS-1:0];
    assign alu_overflow = alu_res[WS];

    typedef struct packed {
        logic [RA-1:0] dst;
        logic [WS-1:0] val;
        logic [WS-1:0] old;
        logic          ovf;
    } exp_t;

    exp_t          sb[$];
    logic [WS-1:0] ref_regs [4];
    logic          ref_ovf;
    int            n_pass  = 0;
    int            n_fail  = 0;
    int            n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow_flag), 32'd0);
        chk({tag, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
        chk({tag, "_alu_r1"}, 32'(alu_r1), 32'd0);
        chk({tag, "_alu_r2"}, 32'(alu_r2), 32'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk($sformatf("%s_reg%0d", tag, i), 32'(dbg_data), 32'd0);
        end
    endtask

    // Issue one instruction, push its expected writeback, then check it when done pulses
    task automatic exec(input string tag, input logic ldi, input logic [1:0] op,
                        input logic [1:0] dst, input logic [1:0] s1, input logic [1:0] s2);
        exp_t          e;
        exp_t          r;
        logic [WS:0]   sum;
        logic [WS-1:0] a;
        logic [WS-1:0] b;
        int            lat;
        lat = 0;
        while (instr_ready !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
        a = ref_regs[s1];
        b = ref_regs[s2];
        if (ldi) begin
            sum   = {1'b0, s1, s2};
            e.ovf = ref_ovf;
        end else begin
            case (op)
                2'd0:    sum = {1'b0, a & b};
                2'd1:    sum = {1'b0, a | b};
                2'd2:    sum = {1'b0, a ^ b};
                default: sum = {1'b0, a} + {1'b0, b};
            endcase
            e.ovf = (op == 2'd3) ? sum[WS] : 1'b0;
        end
        e.dst = dst;
        e.val = sum[WS-1:0];
        e.old = ref_regs[dst];
        sb.push_back(e);
        ref_regs[dst] = e.val;
        ref_ovf       = e.ovf;

        instr       = {ldi, op, dst, s1, s2};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        if (!ldi) begin
            chk({tag, "_issue_ready"}, 32'(instr_ready), 32'd0);
            chk({tag, "_issue_opcode"}, 32'(alu_opcode), 32'(op));
            chk({tag, "_issue_r1"}, 32'(alu_r1), 32'(a));
            chk({tag, "_issue_r2"}, 32'(alu_r2), 32'(b));
        end
        lat = 1;
        while (done !== 1'b1 && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), ldi ? 32'd1 : 32'd2);
        chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            r = sb.pop_front();
            dbg_addr = r.dst;
            #1;
            chk({tag, "_no_bypass"}, 32'(dbg_data), 32'(r.old));
            @(negedge clk);
            chk({tag, "_done_pulse"}, 32'(done), 32'd0);
            chk({tag, "_ready_after"}, 32'(instr_ready), 32'd1);
            chk({tag, "_wb_data"}, 32'(dbg_data), 32'(r.val));
            chk({tag, "_ovf"}, 32'(overflow_flag), 32'(r.ovf));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int n_done;

        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        for (int i = 0; i < 4; i++) ref_regs[i] = '0;
        ref_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_reset_state("reset");
        @(negedge clk);

        // Immediates
        exec("ldi_r0", 1'b1, 2'd0, 2'd0, 2'b01, 2'b00);
        exec("ldi_r1", 1'b1, 2'd0, 2'd1, 2'b00, 2'b10);

        // Logic ops
        exec("and_r2", 1'b0, 2'd0, 2'd2, 2'd0, 2'd1);
        exec("or_r2",  1'b0, 2'd1, 2'd2, 2'd0, 2'd1);
        exec("xor_r3", 1'b0, 2'd2, 2'd3, 2'd2, 2'd0);

        // ADD with carry, LDI keeps the flag, OR clears it
        exec("ldi_r0b", 1'b1, 2'd0, 2'd0, 2'b11, 2'b00);
        exec("ldi_r1b", 1'b1, 2'd0, 2'd1, 2'b01, 2'b01);
        exec("add_r2",  1'b0, 2'd3, 2'd2, 2'd0, 2'd1);
        exec("ldi_r3",  1'b1, 2'd0, 2'd3, 2'b00, 2'b00);
        exec("or_r3",   1'b0, 2'd1, 2'd3, 2'd0, 2'd1);

        // Held valid: one accept per three cycles, XOR r2 = r0 ^ r1 each time
        instr       = {1'b0, 2'd2, 2'd2, 2'd0, 2'd1};
        instr_valid = 1'b1;
        n_acc  = 0;
        n_done = 0;
        for (int i = 0; i < 9; i++) begin
            if (instr_valid && instr_ready) n_acc++;
            if (done) n_done++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("held_accepts", 32'(n_acc), 32'd3);
        chk("held_dones", 32'(n_done), 32'd3);
        ref_regs[2] = ref_regs[0] ^ ref_regs[1];
        ref_ovf     = 1'b0;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        chk("held_no_extra", 32'(n_done), 32'd0);
        dbg_addr = 2'd2;
        #1;
        chk("held_r2", 32'(dbg_data), 32'(ref_regs[2]));
        chk("held_ovf", 32'(overflow_flag), 32'd0);

        // Aliasing: destination equals both sources
        exec("ldi_r1c", 1'b1, 2'd0, 2'd1, 2'b00, 2'b11);
        exec("add_alias", 1'b0, 2'd3, 2'd1, 2'd1, 2'd1);

        // Raise the flag, then abort an ADD during ISSUE
        exec("add_ovf", 1'b0, 2'd3, 2'd2, 2'd0, 2'd0);
        instr       = {1'b0, 2'd3, 2'd3, 2'd0, 2'd1};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("midrst_in_issue", 32'(instr_ready), 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_no_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        chk("midrst_no_late_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) ref_regs[i] = '0;
        ref_ovf = 1'b0;

        // Operation resumes normally after the abort
        exec("post_ldi", 1'b1, 2'd0, 2'd3, 2'b10, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mcpu_alu_sequencer.md
Name: mcpu_alu_sequencer

Overview:
- Sequential initiator that drives the MicroCPU ALU: accepts one instruction at a time over a valid/ready handshake.
- Reads operands from an internal register file, presents opcode/operands to the combinational ALU, captures the ALU result and overflow, and writes the result back.
- Sits between the instruction source (fetch or bench) and the MCPU ALU; the ALU itself stays outside this block.

Parameters:
- CMD_SIZE, 2, ALU opcode width (0=AND, 1=OR, 2=XOR, 3=ADD).
- WORD_SIZE, 4, data word width.
- REG_ADDR, 2, register-file address width; 2**REG_ADDR registers. Constraint: 2*REG_ADDR >= WORD_SIZE.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET_N  in  1  synchronous active-low reset.
- instr_valid  in  1  instruction present.
- instr  in  1+CMD_SIZE+3*REG_ADDR  {ldi, opcode, dst, src1, src2}, ldi at MSB.
- instr_ready  out  1  block can accept an instruction.
- done  out  1  one-cycle pulse on writeback.
- overflow_flag  out  1  carry-out of last ALU instruction.
- alu_opcode  out  CMD_SIZE  to ALU opcode.
- alu_r1  out  WORD_SIZE  to ALU operand 1.
- alu_r2  out  WORD_SIZE  to ALU operand 2.
- alu_out  in  WORD_SIZE  from ALU result.
- alu_overflow  in  1  from ALU OVERFLOW.
- dbg_addr  in  REG_ADDR  debug read address.
- dbg_data  out  WORD_SIZE  combinational read of reg[dbg_addr].

Behaviour:
- Reset, sampled at the clock edge while RESET_N=0:
  - state=IDLE.
  - All registers 0.
  - alu_opcode, alu_r1, alu_r2 = 0.
  - overflow_flag=0, done=0.
  - instr_ready=1 in the first cycle after reset.
- States: IDLE, ISSUE, WB.
- IDLE:
  - instr_ready=1. Accept when instr_valid && instr_ready at edge N; latch instr.
  - ALU instruction (ldi=0): load alu_opcode=opcode, alu_r1=reg[src1], alu_r2=reg[src2]; go to ISSUE.
  - ldi=1: imm = low WORD_SIZE bits of {src1,src2}; go to WB.
- ISSUE (cycle N+1):
  - ALU inputs stable.
  - At the end of the cycle capture alu_out into the result register and alu_overflow into a temporary; go to WB.
- WB:
  - done=1.
  - At the end of the cycle write reg[dst] (result or imm).
  - For ALU ops, overflow_flag <= captured overflow, and only when opcode==3. For AND/OR/XOR overflow_flag <= 0. LDI leaves overflow_flag unchanged.
  - Go to IDLE.
- Latency:
  - ALU op accepted at edge N: done high in cycle N+2, register visible on dbg_data from N+3, instr_ready high again at N+3.
  - LDI: done in cycle N+1, visible from N+2.
- instr_ready=0 in ISSUE and WB. instr_valid is ignored there, and the instruction is not queued; the source must hold it.
- alu_* outputs hold their last values outside ISSUE and are changed only on IDLE accept of an ALU op.
- ADD is modulo 2**WORD_SIZE; the carry goes only to overflow_flag.
- dst==src1/src2: operands are read at accept, so the old value is used and the new value is written in WB.
- Reset during ISSUE or WB aborts the operation: no writeback, no done pulse, full reset values applied.
- dbg_data reflects the write on the cycle after the WB edge; there is no bypass.

Decomposition:
- Package mcpu_pkg holds:
  - Opcode constants OP_AND=0, OP_OR=1, OP_XOR=2, OP_ADD=3.
  - State encoding for IDLE/ISSUE/WB.
  - Instruction field offsets derived from CMD_SIZE/REG_ADDR.
- One natural sub-module: mcpu_regfile. It provides:
  - 2 combinational read ports plus the debug read port.
  - 1 synchronous write port.
  - Synchronous active-low clear.

Test Plan:
- Reset then LDI: LDI r0=4'b0100, LDI r1=4'b0010 -> done 1 cycle after each accept; dbg_data(r0)=0100, (r1)=0010; overflow_flag=0.
- Logic ops with r0=0100, r1=0010: AND r2=r0&r1 -> 0000; OR r2 -> 0110; XOR r3=r2^r0 -> 0010. alu_opcode/alu_r1/alu_r2 correct during ISSUE; done at N+2.
- ADD overflow: LDI r0=1100, r1=0101; ADD r2=r0+r1 -> r2=0001, overflow_flag=1. A following OR clears overflow_flag to 0. LDI between them keeps the flag.
- Handshake: hold instr_valid=1 with back-to-back instructions -> exactly one accept per 3 cycles (ALU op). Instructions presented while instr_ready=0 are not executed twice.
- Aliasing: r1=0011, ADD r1=r1+r1 -> r1=0110, overflow_flag=0.
- Reset mid-op: deassert RESET_N during ISSUE of ADD r3 -> no done pulse, all registers 0, instr_ready=1 the cycle after RESET_N returns high.
